// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the floating-point datapath
// (adder, multiplier, divider).
package fp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int          BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Denormals classify as ZERO so they are flushed on entry.
  function automatic fp_class_t fp_classify(fp32_t v);
    if (v.exp == '0) return ZERO;
    if (v.exp == '1) return (v.man == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_divider_seq_if.sv
// Handshake and operand/result bundle of the sequential divider.
// Carries the underflow flag only when FP_DIV_UNDERFLOW_EN is defined.
interface fp_divider_seq_if;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        ready;
  logic        valid;
  logic [31:0] quotient;
  logic        overflow;
  logic        div_by_zero;
`ifdef FP_DIV_UNDERFLOW_EN
  logic        underflow;

  modport master (output start, x, y,
                  input  ready, valid, quotient, overflow, div_by_zero, underflow);
  modport slave  (input  start, x, y,
                  output ready, valid, quotient, overflow, div_by_zero, underflow);
`else
  modport master (output start, x, y,
                  input  ready, valid, quotient, overflow, div_by_zero);
  modport slave  (input  start, x, y,
                  output ready, valid, quotient, overflow, div_by_zero);
`endif
endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised 24-bit mantissa, shared by the
// floating-point units; reports exponent overflow/underflow after rounding.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W:0]          man_in,
  input  logic                    guard,
  input  logic                    sticky,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic [MAN_W-1:0]        frac_out,
  output logic [EXP_W-1:0]        exp_out,
  output logic                    ovf,
  output logic                    unf
);
  localparam logic signed [EXP_W+1:0] ExpMax  = (EXP_W+2)'(2**EXP_W - 1);
  localparam logic signed [EXP_W+1:0] ExpZero = '0;

  logic                    inc;
  logic [MAN_W+1:0]        sum;
  logic                    carry;
  logic signed [EXP_W+1:0] exp_r;

  always_comb begin
    inc   = guard & (sticky | man_in[0]);
    sum   = {1'b0, man_in} + (MAN_W+2)'(inc);
    carry = sum[MAN_W+1];
    // A carry out leaves 1.000..0, so the renormalised fraction is just the upper bits.
    frac_out = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_r    = exp_in + $signed({{(EXP_W+1){1'b0}}, carry});
    exp_out  = exp_r[EXP_W-1:0];
    ovf      = (exp_r >= ExpMax);
    unf      = (exp_r <= ExpZero);
  end
endmodule

// File: rtl/fp_divider_seq.sv
// Iterative IEEE-754 single divider: radix-2 restoring, one quotient bit per cycle.
// Define FP_DIV_UNDERFLOW_EN to add the underflow flag output.
module fp_divider_seq
  import fp_pkg::*;
#(
  parameter int unsigned Q_BITS = 26
) (
  input logic             clk,
  input logic             rst,
  fp_divider_seq_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(Q_BITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(Q_BITS - 1);

  typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StRound, StDone} state_e;
  state_e state_q, state_d;

  fp32_t                   x_q, y_q;
  logic signed [EXP_W+1:0] exp_q;
  logic [MAN_W:0]          mb_q;
  logic [MAN_W+1:0]        rem_q;
  logic [Q_BITS-1:0]       q_q;
  logic [CntW-1:0]         cnt_q;
  logic [31:0]             res_q, quotient_q;
  logic                    ovf_p_q, dbz_p_q, overflow_q, dbz_q, valid_q;

  logic                    ready, accept, sign;
  fp_class_t               cls_x, cls_y;
  logic                    special, special_dbz;
  logic [31:0]             special_res;
  logic                    ge;
  logic [MAN_W+1:0]        rem_sel;
  logic [Q_BITS-1:0]       q_n;
  logic signed [EXP_W+1:0] exp_n;
  logic                    guard, sticky;
  logic [MAN_W-1:0]        rnd_frac;
  logic [EXP_W-1:0]        rnd_exp;
  logic                    rnd_ovf, rnd_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StUnpack;
      StUnpack: state_d = special ? StDone : StDivide;
      StDivide: if (cnt_q == LastCnt) state_d = StRound;
      StRound:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready  = (state_q == StIdle);
    accept = ready & bus.start;
  end

  always_comb begin
    sign        = x_q.sign ^ y_q.sign;
    cls_x       = fp_classify(x_q);
    cls_y       = fp_classify(y_q);
    special     = 1'b1;
    special_dbz = 1'b0;
    special_res = QNAN;
    if (cls_x == NAN || cls_y == NAN) begin
      special_res = QNAN;
    end else if ((cls_x == ZERO && cls_y == ZERO) || (cls_x == INF && cls_y == INF)) begin
      special_res = QNAN;
    end else if (cls_x == INF) begin
      special_res = POS_INF | {sign, 31'd0};
    end else if (cls_y == ZERO) begin
      special_res = POS_INF | {sign, 31'd0};
      special_dbz = 1'b1;
    end else if (cls_y == INF || cls_x == ZERO) begin
      special_res = {sign, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    ge      = (rem_q >= {1'b0, mb_q});
    rem_sel = ge ? rem_q - {1'b0, mb_q} : rem_q;
    // Quotient lies in [0.5, 2): at most one normalising left shift.
    q_n     = q_q[Q_BITS-1] ? q_q : {q_q[Q_BITS-2:0], 1'b0};
    exp_n   = q_q[Q_BITS-1] ? exp_q : exp_q - $signed((EXP_W+2)'(1));
    guard   = q_n[Q_BITS-MAN_W-2];
    sticky  = (|q_n[Q_BITS-MAN_W-3:0]) | (|rem_q);
  end

  fp_round_rne u_round (
    .man_in   (q_n[Q_BITS-1 -: MAN_W+1]),
    .guard    (guard),
    .sticky   (sticky),
    .exp_in   (exp_n),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .ovf      (rnd_ovf),
    .unf      (rnd_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; exp_q <= '0; mb_q <= '0; rem_q <= '0; q_q <= '0;
      cnt_q <= '0; res_q <= '0; quotient_q <= '0; ovf_p_q <= 1'b0; dbz_p_q <= 1'b0;
      overflow_q <= 1'b0; dbz_q <= 1'b0; valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: if (accept) begin
          x_q        <= bus.x;
          y_q        <= bus.y;
          overflow_q <= 1'b0;
          dbz_q      <= 1'b0;
        end
        StUnpack: begin
          ovf_p_q <= 1'b0;
          dbz_p_q <= special_dbz;
          res_q   <= special_res;
          exp_q   <= (EXP_W+2)'(int'(x_q.exp) - int'(y_q.exp) + BIAS);
          mb_q    <= {1'b1, y_q.man};
          rem_q   <= {2'b01, x_q.man};
          q_q     <= '0;
          cnt_q   <= '0;
        end
        StDivide: begin
          rem_q <= rem_sel << 1;
          q_q   <= {q_q[Q_BITS-2:0], ge};
          cnt_q <= cnt_q + 1'b1;
        end
        StRound: begin
          ovf_p_q <= rnd_ovf;
          if (rnd_ovf)      res_q <= POS_INF | {sign, 31'd0};
          else if (rnd_unf) res_q <= {sign, 31'd0};
          else              res_q <= {sign, rnd_exp, rnd_frac};
        end
        StDone: begin
          valid_q    <= 1'b1;
          quotient_q <= res_q;
          overflow_q <= ovf_p_q;
          dbz_q      <= dbz_p_q;
        end
        default: ;
      endcase
    end
  end

`ifdef FP_DIV_UNDERFLOW_EN
  logic unf_p_q, unf_q;

  // Only the normal path can underflow; specials leave the pending flag clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unf_p_q <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (accept)               unf_q   <= 1'b0;
      if (state_q == StUnpack)  unf_p_q <= 1'b0;
      if (state_q == StRound)   unf_p_q <= rnd_unf;
      if (state_q == StDone)    unf_q   <= unf_p_q;
    end
  end

  assign bus.underflow = unf_q;
`else
  // Results below the normal range are flushed to signed zero without a flag.
`endif

  assign bus.ready       = ready;
  assign bus.valid       = valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_divider_seq.sv
// Self-checking bench for fp_divider_seq: directed cases plus random operands checked
// against an exact integer reference of IEEE division with round-to-nearest-even.
module tb_fp_divider_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  fp_divider_seq_if dif ();

  fp_divider_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, want);
    end
  endtask

  // Exact quotient via wide integer division, then RNE on the true remainder.
  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q,
                       output logic ovf, output logic dbz, output logic unf, output int lat);
    int ea, eb, e, sh;
    logic s, za, zb, ia, ib, na, nb;
    longint ma, mb, qq, rr, mant, low, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ovf = 1'b0; dbz = 1'b0; unf = 1'b0; lat = 2;
    if (na || nb || (za && zb) || (ia && ib)) q = 32'h7FC00000;
    else if (ia) q = {s, 8'hff, 23'd0};
    else if (zb) begin q = {s, 8'hff, 23'd0}; dbz = 1'b1; end
    else if (ib || za) q = {s, 31'd0};
    else begin
      lat  = 29;
      ma   = longint'({1'b1, a[22:0]});
      mb   = longint'({1'b1, b[22:0]});
      qq   = (ma << 26) / mb;
      rr   = (ma << 26) % mb;
      sh   = (qq >= (longint'(1) << 26)) ? 3 : 2;
      e    = ea - eb + 127 - ((sh == 2) ? 1 : 0);
      mant = qq >> sh;
      low  = qq & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (low > half || (low == half && (rr != 0 || mant[0]))) mant++;
      if (mant == (longint'(1) << 24)) begin mant = mant >> 1; e++; end
      if (e >= 255) begin q = {s, 8'hff, 23'd0}; ovf = 1'b1; end
      else if (e <= 0) begin q = {s, 31'd0}; unf = 1'b1; end
      else q = {s, 8'(e), 23'(mant)};
    end
  endtask

  // Called on a negedge; start is seen by the following posedge.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    dif.x = a;
    dif.y = b;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    check({tag, "/ready_low"}, 32'(dif.ready), 32'd0);
    check({tag, "/flags_clr"}, {30'd0, dif.overflow, dif.div_by_zero}, 32'd0);
  endtask

  task automatic wait_result(input string tag, input int lat0, input logic [31:0] want_q,
                             input logic want_ovf, input logic want_dbz, input logic want_unf,
                             input int want_lat, input bit pulse);
    int lat = lat0;
    while (dif.valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/valid"}, 32'(dif.valid), 32'd1);
    if (dif.valid !== 1'b1) return;
    check({tag, "/lat"}, 32'(lat), 32'(want_lat));
    check({tag, "/q"}, dif.quotient, want_q);
    check({tag, "/ovf"}, 32'(dif.overflow), 32'(want_ovf));
    check({tag, "/dbz"}, 32'(dif.div_by_zero), 32'(want_dbz));
`ifdef FP_DIV_UNDERFLOW_EN
    check({tag, "/unf"}, 32'(dif.underflow), 32'(want_unf));
`else
    if (want_unf === 1'bx) $display("unexpected unknown underflow expectation");
`endif
    check({tag, "/ready"}, 32'(dif.ready), 32'd1);
    if (pulse) begin
      @(negedge clk);
      check({tag, "/pulse"}, 32'(dif.valid), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_norm();
    logic [7:0] e;
    if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(100, 154));
    else                           e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_any();
    logic s = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       return {s, 8'd0, 23'($urandom)};
      1:       return {s, 8'hff, 23'd0};
      2:       return {s, 8'hff, 23'($urandom) | 23'd1};
      default: return rand_norm();
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, q;
    logic o, d, u;
    int l;
    rst = 1'b1;
    dif.start = 1'b0;
    dif.x = '0;
    dif.y = '0;
    repeat (2) @(negedge clk);
    check("rst/ready", 32'(dif.ready), 32'd1);
    check("rst/valid", 32'(dif.valid), 32'd0);
    check("rst/q", dif.quotient, 32'd0);
    check("rst/flags", {30'd0, dif.overflow, dif.div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op("6/2", 32'h40C00000, 32'h40000000);
    wait_result("6/2", 0, 32'h40400000, 0, 0, 0, 29, 1);
    start_op("1/3", 32'h3F800000, 32'h40400000);
    wait_result("1/3", 0, 32'h3EAAAAAB, 0, 0, 0, 29, 1);
    start_op("-1/3", 32'hBF800000, 32'h40400000);
    wait_result("-1/3", 0, 32'hBEAAAAAB, 0, 0, 0, 29, 1);
    start_op("1/0", 32'h3F800000, 32'h00000000);
    wait_result("1/0", 0, 32'h7F800000, 0, 1, 0, 2, 1);
    start_op("0/0", 32'h00000000, 32'h00000000);
    wait_result("0/0", 0, 32'h7FC00000, 0, 0, 0, 2, 1);
    start_op("1/inf", 32'h3F800000, 32'h7F800000);
    wait_result("1/inf", 0, 32'h00000000, 0, 0, 0, 2, 1);
    start_op("ovf", 32'h7F7FFFFF, 32'h3F000000);
    wait_result("ovf", 0, 32'h7F800000, 1, 0, 0, 29, 1);
    start_op("unf", 32'h00800000, 32'h40000000);
    wait_result("unf", 0, 32'h00000000, 0, 0, 1, 29, 1);

    // A start with other operands mid-divide must be ignored.
    start_op("busy", 32'h40C00000, 32'h40000000);
    repeat (9) @(negedge clk);
    dif.x = 32'h3F800000;
    dif.y = 32'h40400000;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_result("busy", 10, 32'h40400000, 0, 0, 0, 29, 0);
    // Back-to-back: start issued in the valid cycle.
    start_op("b2b", 32'hBF800000, 32'h40400000);
    wait_result("b2b", 0, 32'hBEAAAAAB, 0, 0, 0, 29, 1);

    // Asynchronous reset in the middle of DIVIDE.
    start_op("arst", 32'h3F800000, 32'h40400000);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst/ready", 32'(dif.ready), 32'd1);
    check("arst/valid", 32'(dif.valid), 32'd0);
    check("arst/q", dif.quotient, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_op("post_rst", 32'h40C00000, 32'h40000000);
    wait_result("post_rst", 0, 32'h40400000, 0, 0, 0, 29, 1);

    for (int i = 0; i < 40; i++) begin
      a = rand_norm();
      b = rand_norm();
      model(a, b, q, o, d, u, l);
      start_op("rnd_norm", a, b);
      wait_result("rnd_norm", 0, q, o, d, u, l, (i % 2) == 0);
    end
    for (int i = 0; i < 30; i++) begin
      a = rand_any();
      b = rand_any();
      model(a, b, q, o, d, u, l);
      start_op("rnd_any", a, b);
      wait_result("rnd_any", 0, q, o, d, u, l, (i % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
